// File: rtl/ram_ctrl.sv
// Initiator-side controller for a single-port RAM with a shared bidirectional data bus.
// Define RAM_CTRL_INIT_EN to zero-fill the whole RAM after every reset before accepting requests.
module ram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    TURN,
    RD,
`ifdef RAM_CTRL_INIT_EN
    RESP,
    INIT
`else
    RESP
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_wr_en_q, ram_wr_en_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0]            cnt_q, cnt_d;
`ifdef RAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
`endif

  // The bus is only ever driven while the registered write enable is high,
  // so the RAM and the controller can never fight over it.
  assign ram_data  = ram_wr_en_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr_en = ram_wr_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_en_d = ram_wr_en_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
`ifdef RAM_CTRL_INIT_EN
    init_addr_d = init_addr_q;
`endif

    case (state_q)
      IDLE: begin
        // req_ready_q is low on the first IDLE cycle after reset, which gates acceptance.
        if (req_valid && req_ready_q) begin
          ram_addr_d = req_addr;
          if (req_we) begin
            wdata_d     = req_wdata;
            ram_wr_en_d = 1'b1;
            state_d     = WR;
          end else begin
            ram_wr_en_d = 1'b0;
            cnt_d       = 3'(RD_LATENCY);
            state_d     = RD;
          end
        end
      end
      WR: begin
        ram_wr_en_d = 1'b0;
        state_d     = TURN;
      end
      TURN: begin
        state_d = IDLE;
      end
      RD: begin
        if (cnt_q == 3'd0) begin
          rsp_rdata_d = ram_data;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
`ifdef RAM_CTRL_INIT_EN
      INIT: begin
        // Alternate a write cycle with a release cycle for every address.
        if (ram_wr_en_q) begin
          ram_wr_en_d = 1'b0;
          if (init_addr_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = IDLE;
          end else begin
            init_addr_d = init_addr_q + 1'b1;
          end
        end else begin
          ram_wr_en_d = 1'b1;
          ram_addr_d  = init_addr_q;
          wdata_d     = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RAM_CTRL_INIT_EN
      state_q     <= INIT;
      busy_q      <= 1'b1;
      init_addr_q <= '0;
`else
      state_q     <= IDLE;
      busy_q      <= 1'b0;
`endif
      req_ready_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wr_en_q <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_en_q <= ram_wr_en_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
`ifdef RAM_CTRL_INIT_EN
      init_addr_q <= init_addr_d;
`endif
    end
  end

endmodule
